// File: rtl/axi4_lite_read_master.sv
// axi4_lite_read_master: single-outstanding AXI4-lite read initiator.
// Accepts one core read request, issues it on AR, collects the beat on R
// and holds the response until the core takes it.
// Optional build macro: AXI_RD_TIMEOUT_EN adds a per-phase wait limit
// (TIMEOUT_CYCLES) that aborts a stalled read with rsp_err=1, rsp_data=0.
module axi4_lite_read_master #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [2:0]        ar_prot,
  output logic              ar_valid,
  input  logic              ar_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_valid,
  output logic              r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ar_valid_q, ar_valid_d;
  logic                r_ready_q, r_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [2:0]          ar_prot_q, ar_prot_d;

`ifdef AXI_RD_TIMEOUT_EN
  // Counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Next-state and next-output computation for the read sequencer.
  always_comb begin
    state_d     = state_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    ar_addr_d   = ar_addr_q;
    ar_prot_d   = ar_prot_q;
`ifdef AXI_RD_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ar_addr_d  = req_addr;
          ar_prot_d  = req_prot;
          ar_valid_d = 1'b1;
          state_d    = ADDR;
`ifdef AXI_RD_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          state_d    = IDLE;
        end
      end
      ADDR: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = DATA;
`ifdef AXI_RD_TIMEOUT_EN
          cnt_d      = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Slave never accepted the address: abort with an error response.
          ar_valid_d  = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d    = ADDR;
        end
`endif
      end
      DATA: begin
        if (r_valid) begin
          // Only resp[1] marks an error; EXOKAY counts as OKAY.
          rsp_data_d  = r_data;
          rsp_err_d   = r_resp[1];
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef AXI_RD_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // Slave never returned data: abort with an error response.
          r_ready_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d     = DATA;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        ar_valid_d  = 1'b0;
        r_ready_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      ar_addr_q   <= '0;
      ar_prot_q   <= 3'b000;
`ifdef AXI_RD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      ar_addr_q   <= ar_addr_d;
      ar_prot_q   <= ar_prot_d;
`ifdef AXI_RD_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign ar_valid  = ar_valid_q;
  assign ar_addr   = ar_addr_q;
  assign ar_prot   = ar_prot_q;
  assign r_ready   = r_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/axi4_lite_read_master.md
Name: axi4_lite_read_master

Overview:
- AXI4-lite read initiator: accepts single-beat read requests from a core-side request/response interface, issues them on the AR channel and collects read data on the R channel.
- Sits between the NPC load/fetch unit and any AXI4-lite read slave.
- One outstanding transaction at a time; no bursts.

Parameters:
- ADDR_W, 64, address width of req_addr and ar_addr
- DATA_W, 64, data width of r_data and rsp_data
- TIMEOUT_CYCLES, 255, wait limit per channel phase; used only with AXI_RD_TIMEOUT_EN

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-high
- req_valid  in  1  core read request valid
- req_ready  out  1  master can accept a request
- req_addr  in  ADDR_W  read address
- req_prot  in  3  AXI protection bits for the request
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  core accepts response
- rsp_data  out  DATA_W  read data
- rsp_err  out  1  1 = SLVERR/DECERR or timeout
- ar_addr  out  ADDR_W  AR address
- ar_prot  out  3  AR protection
- ar_valid  out  1  AR valid
- ar_ready  in  1  AR ready from slave
- r_data  in  DATA_W  R data
- r_resp  in  2  R response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
- r_valid  in  1  R valid from slave
- r_ready  out  1  R ready to slave

Behaviour:
- All outputs registered, driven only from state and captured registers.
- Reset (rst=1, any time, including mid-transaction): state=IDLE; ar_valid=0, r_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, ar_addr=0, ar_prot=0. req_ready=1 is driven from state, so it is high out of reset. An abandoned slave transaction is not tracked.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch req_addr/req_prot into ar_addr/ar_prot, set ar_valid=1, go to ADDR.
- ADDR:
  - ar_valid=1; ar_addr/ar_prot held stable; req_ready=0.
  - On ar_valid & ar_ready: ar_valid=0, r_ready=1, go to DATA.
  - r_valid is ignored while in ADDR (r_ready=0).
- DATA:
  - r_ready=1.
  - On r_valid & r_ready: capture rsp_data=r_data and rsp_err=r_resp[1]; r_ready=0, rsp_valid=1, go to RESP.
  - EXOKAY is treated as OKAY.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake; no bypass.
- Latency:
  - Request handshake at edge N gives ar_valid=1 at N+1.
  - If ar_ready=1 immediately: r_ready=1 at N+2.
  - If r_valid=1 immediately: rsp_valid=1 at N+3.
  - Minimum request-to-response latency is 3 cycles; throughput is at most one read per 4 cycles.
- Back-pressure: ar_ready, r_valid and rsp_ready may each stay low indefinitely. The master waits with outputs stable.
- ar_addr is forwarded unmodified; no alignment check.

Optional Feature:
- AXI_RD_TIMEOUT_EN:
  - When defined, an 8-bit-or-wider counter clears on entry to ADDR and DATA and increments each cycle spent waiting in either state.
  - When the count reaches TIMEOUT_CYCLES: drop ar_valid/r_ready, set rsp_data=0, rsp_err=1, rsp_valid=1, go to RESP.
  - A late r_valid after a timeout is ignored (r_ready=0 in IDLE/RESP).
- When not defined: no counter; the master waits forever.

Test Plan:
- Zero-wait read: req_addr=0x8000_0000, ar_ready=1, r_valid=1 with r_data=0x1122_3344_5566_7788, r_resp=00 -> ar_valid pulses one cycle with addr 0x8000_0000; rsp_valid 3 cycles after the request handshake; rsp_data=0x1122334455667788; rsp_err=0.
- AR back-pressure: ar_ready held low for 5 cycles -> ar_valid and ar_addr=0x8000_0010 stable all 5 cycles; r_ready=0 throughout; the transaction proceeds when ar_ready rises.
- Error and response stall: r_resp=11 and rsp_ready held low for 4 cycles -> rsp_valid=1, rsp_err=1, rsp_data stable 4 cycles; req_ready=0 until the cycle after rsp_ready.
- Spurious r_valid: r_valid=1 during IDLE and ADDR -> r_ready stays 0 and nothing is captured; the correct data is captured only in DATA.
- Reset mid-op: assert rst while in DATA with r_ready=1 -> ar_valid, r_ready and rsp_valid all go to 0 immediately without a clock edge; after release, req_ready=1 and the next read completes normally.
- Timeout (AXI_RD_TIMEOUT_EN, TIMEOUT_CYCLES=8): ar_ready held 0 -> after 8 waiting cycles ar_valid=0, rsp_valid=1, rsp_err=1, rsp_data=0.
